// File: rtl/timer_pkg.sv
// Shared types and default sizes for the down-counting timer.
package timer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } timer_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises tick for one cycle every prescale+1 enabled cycles.
module tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // >= rather than == so lowering prescale mid-run ticks at once instead of wrapping.
  assign tick = en && (cnt >= prescale);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down timer: load/start/stop control, one-shot or periodic reload,
// registered one-cycle terminal-count pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic [WIDTH-1:0] out_n;
  logic             tc_n;
  logic             tick;
  logic             pre_en;

  // load and stop both freeze the prescaler so the command wins over a tick.
  assign pre_en = (state_q == RUN) && !load && !stop;

  tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
    .clk      (clk),
    .clr      (clr),
    .en       (pre_en),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      reload_q <= '0;
      out      <= '0;
      tc       <= 1'b0;
    end else begin
      state_q  <= state_n;
      reload_q <= reload_n;
      out      <= out_n;
      tc       <= tc_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    reload_n = reload_q;
    out_n    = out;
    tc_n     = 1'b0;
    if (load) begin
      reload_n = load_val;
      out_n    = load_val;
      state_n  = (start && (load_val != '0)) ? RUN : IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_n = PAUSE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start && (out != '0)) state_n = RUN;
        end
        EXPIRED: begin
          if (start && (reload_q != '0)) begin
            out_n   = reload_q;
            state_n = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (out > ONE) begin
              out_n = out - ONE;
            end else if (out == ONE) begin
              tc_n = 1'b1;
              if (periodic) begin
                out_n = reload_q;
              end else begin
                out_n   = '0;
                state_n = EXPIRED;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign state = state_q;

endmodule
